// File: rtl/matrix_pkg.sv
// Shared sizing constants and state types for the matrix writeback path.
package matrix_pkg;

  localparam int XLEN   = 32;
  localparam int ROWS   = 4;
  localparam int MIDX_W = 2;
  localparam int ROW_W  = $clog2(ROWS);

  typedef enum logic {MWB_IDLE, MWB_DRAIN} mwb_state_t;
  typedef enum logic {RR_LINE, RR_MOPA} rr_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter (line vs MOPA) for the MRF write port.
// rr_last_q remembers the most recent winner; the other side wins the next tie.
module wb_rr_arbiter
  import matrix_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line_req_i,
  input  logic mopa_req_i,
  output logic line_gnt_o,
  output logic mopa_gnt_o
);

  rr_req_t rr_last_q;

  // NOTE: every output of an always_comb is assigned on every path, so no latch can be inferred.
  always_comb begin
    line_gnt_o = line_req_i && (!mopa_req_i || (rr_last_q == RR_MOPA));
    mopa_gnt_o = mopa_req_i && (!line_req_i || (rr_last_q == RR_LINE));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= RR_MOPA;
    end else if (line_gnt_o) begin
      rr_last_q <= RR_LINE;
    end else if (mopa_gnt_o) begin
      rr_last_q <= RR_MOPA;
    end
  end

endmodule

// File: rtl/matrix_wb_sequencer.sv
// MRF single-row writeback sequencer: arbitrates line writes against MOPA results and
// serialises each MOPA result one row per cycle. MWB_PREEMPT_EN lets line writes preempt a drain.
module matrix_wb_sequencer
  import matrix_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_valid,
  output logic                   line_ready,
  input  logic [MIDX_W-1:0]      line_midx,
  input  logic [ROW_W-1:0]       line_row,
  input  logic [XLEN-1:0]        line_data,
  input  logic                   mopa_valid,
  output logic                   mopa_ready,
  input  logic [MIDX_W-1:0]      mopa_midx,
  input  logic [ROWS*XLEN-1:0]   mopa_data,
  output logic                   mrf_we,
  output logic [MIDX_W-1:0]      mrf_midx,
  output logic [ROW_W-1:0]       mrf_row,
  output logic [XLEN-1:0]        mrf_data,
  output logic                   drain_busy,
  output logic [MIDX_W-1:0]      drain_midx
);

`ifdef MWB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  mwb_state_t          state_q;
  logic [ROW_W-1:0]    cnt_q;
  logic [MIDX_W-1:0]   buf_midx_q;
  logic [XLEN-1:0]     buf_q [ROWS];
  logic                mrf_we_q;
  logic [MIDX_W-1:0]   mrf_midx_q;
  logic [ROW_W-1:0]    mrf_row_q;
  logic [XLEN-1:0]     mrf_data_q;

  logic line_req, mopa_req, line_gnt, mopa_gnt;

  // A drain blocks new MOPA results; line writes only get in during a drain when preemption is built in.
  assign line_req = line_valid && ((state_q == MWB_IDLE) || PREEMPT);
  assign mopa_req = mopa_valid && (state_q == MWB_IDLE);

  wb_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .line_req_i (line_req),
    .mopa_req_i (mopa_req),
    .line_gnt_o (line_gnt),
    .mopa_gnt_o (mopa_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MWB_IDLE;
      cnt_q      <= '0;
      buf_midx_q <= '0;
      // NOTE: the row buffer is small and must not leak stale rows after reset, so it is cleared here.
      for (int r = 0; r < ROWS; r++) buf_q[r] <= '0;
      mrf_we_q   <= 1'b0;
      mrf_midx_q <= '0;
      mrf_row_q  <= '0;
      mrf_data_q <= '0;
    end else begin
      mrf_we_q <= 1'b0;
      if (line_gnt) begin
        // In DRAIN this is a preempting line write: cnt holds and the drain resumes next cycle.
        mrf_we_q   <= 1'b1;
        mrf_midx_q <= line_midx;
        mrf_row_q  <= line_row;
        mrf_data_q <= line_data;
      end else begin
        case (state_q)
          MWB_IDLE: begin
            if (mopa_gnt) begin
              mrf_we_q   <= 1'b1;
              mrf_midx_q <= mopa_midx;
              mrf_row_q  <= '0;
              mrf_data_q <= mopa_data[0 +: XLEN];
              for (int r = 0; r < ROWS; r++) buf_q[r] <= mopa_data[r*XLEN +: XLEN];
              buf_midx_q <= mopa_midx;
              cnt_q      <= ROW_W'(1);
              state_q    <= MWB_DRAIN;
            end
          end
          MWB_DRAIN: begin
            mrf_we_q   <= 1'b1;
            mrf_midx_q <= buf_midx_q;
            mrf_row_q  <= cnt_q;
            mrf_data_q <= buf_q[cnt_q];
            if (cnt_q == LAST_ROW) begin
              cnt_q   <= '0;
              state_q <= MWB_IDLE;
            end else begin
              cnt_q <= cnt_q + ROW_W'(1);
            end
          end
          default: state_q <= MWB_IDLE;
        endcase
      end
    end
  end

  assign line_ready = line_gnt;
  assign mopa_ready = mopa_gnt;
  assign mrf_we     = mrf_we_q;
  assign mrf_midx   = mrf_midx_q;
  assign mrf_row    = mrf_row_q;
  assign mrf_data   = mrf_data_q;
  assign drain_busy = (state_q == MWB_DRAIN);
  assign drain_midx = buf_midx_q;

endmodule

// File: tb/tb_matrix_wb_sequencer.sv
// Self-checking bench for matrix_wb_sequencer: queue-based reference model plus directed literal checks.
module tb_matrix_wb_sequencer;
  import matrix_pkg::*;

`ifdef MWB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 line_valid, line_ready;
  logic [MIDX_W-1:0]    line_midx;
  logic [ROW_W-1:0]     line_row;
  logic [XLEN-1:0]      line_data;
  logic                 mopa_valid, mopa_ready;
  logic [MIDX_W-1:0]    mopa_midx;
  logic [ROWS*XLEN-1:0] mopa_data;
  logic                 mrf_we;
  logic [MIDX_W-1:0]    mrf_midx;
  logic [ROW_W-1:0]     mrf_row;
  logic [XLEN-1:0]      mrf_data;
  logic                 drain_busy;
  logic [MIDX_W-1:0]    drain_midx;

  matrix_wb_sequencer dut (
    .clk(clk), .rst(rst),
    .line_valid(line_valid), .line_ready(line_ready), .line_midx(line_midx),
    .line_row(line_row), .line_data(line_data),
    .mopa_valid(mopa_valid), .mopa_ready(mopa_ready), .mopa_midx(mopa_midx),
    .mopa_data(mopa_data),
    .mrf_we(mrf_we), .mrf_midx(mrf_midx), .mrf_row(mrf_row), .mrf_data(mrf_data),
    .drain_busy(drain_busy), .drain_midx(drain_midx)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of rows still owed to the MRF plus the last round-robin winner.
  typedef struct {
    logic [MIDX_W-1:0] midx;
    logic [ROW_W-1:0]  row;
    logic [XLEN-1:0]   data;
  } wr_t;

  wr_t               pend[$];
  bit                m_last_mopa;
  logic [MIDX_W-1:0] m_dmidx;
  bit                e_we;
  wr_t               e_wr;
  bit                m_lr, m_mr;
  logic              lr_seen, mr_seen;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    pend.delete();
    m_last_mopa = 1'b1;
    m_dmidx     = '0;
    e_we        = 1'b0;
    e_wr        = '{midx: '0, row: '0, data: '0};
  endtask

  task automatic compare_model();
    check("mrf_we", {63'd0, mrf_we}, {63'd0, e_we});
    if (e_we) begin
      check("mrf_midx", 64'(mrf_midx), 64'(e_wr.midx));
      check("mrf_row",  64'(mrf_row),  64'(e_wr.row));
      check("mrf_data", 64'(mrf_data), 64'(e_wr.data));
    end
    check("drain_busy", {63'd0, drain_busy}, {63'd0, pend.size() != 0});
    check("drain_midx", 64'(drain_midx), 64'(m_dmidx));
  endtask

  // One clock cycle: compare registered outputs, drive inputs, compare readies, advance the model.
  task automatic step(input bit lv, input logic [MIDX_W-1:0] lm, input logic [ROW_W-1:0] lr,
                      input logic [XLEN-1:0] ld, input bit mv, input logic [MIDX_W-1:0] mm,
                      input logic [ROWS*XLEN-1:0] md);
    @(negedge clk);
    compare_model();
    line_valid = lv; line_midx = lm; line_row = lr; line_data = ld;
    mopa_valid = mv; mopa_midx = mm; mopa_data = md;
    #1;
    if (pend.size() == 0) begin
      m_lr = lv && (!mv || m_last_mopa);
      m_mr = mv && (!lv || !m_last_mopa);
    end else begin
      m_lr = lv && PREEMPT;
      m_mr = 1'b0;
    end
    check("line_ready", {63'd0, line_ready}, {63'd0, m_lr});
    check("mopa_ready", {63'd0, mopa_ready}, {63'd0, m_mr});
    lr_seen = line_ready;
    mr_seen = mopa_ready;
    @(posedge clk);
    if (m_lr) begin
      e_we = 1'b1;
      e_wr = '{midx: lm, row: lr, data: ld};
      m_last_mopa = 1'b0;
    end else if (m_mr) begin
      e_we = 1'b1;
      e_wr = '{midx: mm, row: '0, data: md[0 +: XLEN]};
      for (int r = 1; r < ROWS; r++)
        pend.push_back('{midx: mm, row: ROW_W'(r), data: md[r*XLEN +: XLEN]});
      m_last_mopa = 1'b1;
      m_dmidx = mm;
    end else if (pend.size() != 0) begin
      e_we = 1'b1;
      e_wr = pend.pop_front();
    end else begin
      e_we = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    line_valid = 1'b0;
    mopa_valid = 1'b0;
    rst = 1'b1;
    #1;
    check({tag, "_we"},    {63'd0, mrf_we},     64'd0);
    check({tag, "_busy"},  {63'd0, drain_busy}, 64'd0);
    check({tag, "_midx"},  64'(mrf_midx),       64'd0);
    check({tag, "_row"},   64'(mrf_row),        64'd0);
    check({tag, "_data"},  64'(mrf_data),       64'd0);
    check({tag, "_dmidx"}, 64'(drain_midx),     64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [ROWS*XLEN-1:0] rand_mopa();
    logic [ROWS*XLEN-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*XLEN +: XLEN] = $urandom;
    return v;
  endfunction

  logic [ROWS*XLEN-1:0] blk_a, blk_b, blk_c;
  bit exp_lr3 [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  bit exp_mr3 [10] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    rst = 1'b1;
    line_valid = 1'b0; line_midx = '0; line_row = '0; line_data = '0;
    mopa_valid = 1'b0; mopa_midx = '0; mopa_data = '0;
    model_reset();
    #12;
    check("rst_we",    {63'd0, mrf_we},     64'd0);
    check("rst_busy",  {63'd0, drain_busy}, 64'd0);
    check("rst_dmidx", 64'(drain_midx),     64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single line write.
    step(1'b1, 2'd2, 2'd1, 32'hDEADBEEF, 1'b0, '0, '0);
    check("t1_ready", {63'd0, lr_seen}, 64'd1);
    check("t1_we",    {63'd0, mrf_we},  64'd1);
    check("t1_midx",  64'(mrf_midx),    64'd2);
    check("t1_row",   64'(mrf_row),     64'd1);
    check("t1_data",  64'(mrf_data),    64'hDEADBEEF);

    // Single MOPA result, rows appear on consecutive cycles.
    blk_a = {32'h13, 32'h12, 32'h11, 32'h10};
    step(1'b0, '0, '0, '0, 1'b1, 2'd3, blk_a);
    check("t2_ready", {63'd0, mr_seen}, 64'd1);
    for (int r = 0; r < ROWS; r++) begin
      if (r > 0) idle();
      check("t2_we",    {63'd0, mrf_we},     64'd1);
      check("t2_midx",  64'(mrf_midx),       64'd3);
      check("t2_row",   64'(mrf_row),        64'(r));
      check("t2_data",  64'(mrf_data),       64'(32'h10 + r));
      check("t2_busy",  {63'd0, drain_busy}, 64'(r < ROWS - 1));
      check("t2_dmidx", 64'(drain_midx),     64'd3);
    end
    idle();
    check("t2_gap_we", {63'd0, mrf_we}, 64'd0);

    // Both requesters held valid from reset: strict alternation, no starvation.
    do_reset("t3_rst");
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 2'd1, ROW_W'(k), 32'hA000 + k, 1'b1, 2'd2, rand_mopa());
      if (!PREEMPT) begin
        check("t3_lr", {63'd0, lr_seen}, 64'(exp_lr3[k]));
        check("t3_mr", {63'd0, mr_seen}, 64'(exp_mr3[k]));
      end
    end
    idle(); idle(); idle(); idle();

    // Back-to-back MOPA; data outside the accept cycle must be ignored.
    blk_a = rand_mopa();
    blk_b = rand_mopa();
    for (int k = 0; k < 2 * ROWS; k++) begin
      step(1'b0, '0, '0, '0, 1'b1, MIDX_W'(k / ROWS),
           (k == 0) ? blk_a : (k == ROWS) ? blk_b : rand_mopa());
      check("t4_we",  {63'd0, mrf_we}, 64'd1);
      check("t4_row", 64'(mrf_row),    64'(k % ROWS));
      check("t4_data", 64'(mrf_data),
            (k < ROWS) ? 64'(blk_a[(k % ROWS)*XLEN +: XLEN]) : 64'(blk_b[(k % ROWS)*XLEN +: XLEN]));
      if (k % ROWS == 0) check("t4_mr", {63'd0, mr_seen}, 64'd1);
    end
    idle(); idle(); idle(); idle();

    // Reset in the middle of a drain discards the remaining rows.
    step(1'b0, '0, '0, '0, 1'b1, 2'd1, rand_mopa());
    idle();
    check("t5_row1", 64'(mrf_row), 64'd1);
    do_reset("t5_rst");
    idle();
    check("t5_norows", {63'd0, mrf_we}, 64'd0);
    step(1'b1, 2'd1, 2'd2, 32'hCAFEF00D, 1'b0, '0, '0);
    check("t5_line_we",   {63'd0, mrf_we}, 64'd1);
    check("t5_line_data", 64'(mrf_data),   64'hCAFEF00D);
    idle();
    check("t5_after_we", {63'd0, mrf_we}, 64'd0);

    // Line write arriving in the row-2 slot of a drain.
    blk_c = {32'h23, 32'h22, 32'h21, 32'h20};
    step(1'b0, '0, '0, '0, 1'b1, 2'd1, blk_c);
    idle();
    step(1'b1, 2'd0, 2'd3, 32'h55, 1'b0, '0, '0);
    if (PREEMPT) begin
      check("t6_lr",    {63'd0, lr_seen}, 64'd1);
      check("t6_ldata", 64'(mrf_data),    64'h55);
      idle();
      check("t6_row2",  64'(mrf_data),    64'h22);
      idle();
      check("t6_row3",  64'(mrf_data),    64'h23);
    end else begin
      check("t6_lr",    {63'd0, lr_seen}, 64'd0);
      check("t6_row2",  64'(mrf_data),    64'h22);
      step(1'b1, 2'd0, 2'd3, 32'h55, 1'b0, '0, '0);
      check("t6_lr2",   {63'd0, lr_seen}, 64'd0);
      check("t6_row3",  64'(mrf_data),    64'h23);
      step(1'b1, 2'd0, 2'd3, 32'h55, 1'b0, '0, '0);
      check("t6_lr3",   {63'd0, lr_seen}, 64'd1);
      check("t6_ldata", 64'(mrf_data),    64'h55);
    end
    idle(); idle();

    // Randomised traffic with occasional mid-stream resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
      step(1'($urandom_range(0, 1)), MIDX_W'($urandom), ROW_W'($urandom), $urandom,
           1'($urandom_range(0, 2) != 0), MIDX_W'($urandom), rand_mopa());
    end
    idle();
    @(negedge clk);
    compare_model();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
